// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, EXE command and branch encodings, ID/EX control bundle.
package id_pkg;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    typedef enum logic [3:0] {
        EXE_NOP = 4'd0,
        EXE_ADD = 4'd1,
        EXE_SUB = 4'd2,
        EXE_AND = 4'd3,
        EXE_OR  = 4'd4,
        EXE_NOR = 4'd5,
        EXE_XOR = 4'd6,
        EXE_SLA = 4'd7,
        EXE_SLL = 4'd8,
        EXE_SRA = 4'd9,
        EXE_SRL = 4'd10
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    // Control half of the ID/EX bundle; the data fields are sized by the stage parameters.
    typedef struct packed {
        logic       valid;
        logic [3:0] cmd;
        logic [1:0] br_type;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_stage_pipe_decoder.sv
// id_decoder: purely combinational control unit mapping the 6-bit opcode to EXE controls.
module id_decoder
    import id_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [3:0] exe_cmd_o,
    output logic [1:0] br_type_o,
    output logic       wb_en_o,
    output logic       mem_r_en_o,
    output logic       mem_w_en_o,
    output logic       is_imm_o,
    output logic       uses_src2_o
);

    always_comb begin
        exe_cmd_o   = EXE_NOP;
        br_type_o   = BR_NONE;
        wb_en_o     = 1'b0;
        mem_r_en_o  = 1'b0;
        mem_w_en_o  = 1'b0;
        is_imm_o    = 1'b0;
        uses_src2_o = 1'b0;
        case (opcode_i)
            OP_ADD:  begin exe_cmd_o = EXE_ADD; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_SUB:  begin exe_cmd_o = EXE_SUB; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_AND:  begin exe_cmd_o = EXE_AND; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_OR:   begin exe_cmd_o = EXE_OR;  wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_NOR:  begin exe_cmd_o = EXE_NOR; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_XOR:  begin exe_cmd_o = EXE_XOR; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_SLA:  begin exe_cmd_o = EXE_SLA; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_SLL:  begin exe_cmd_o = EXE_SLL; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_SRA:  begin exe_cmd_o = EXE_SRA; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_SRL:  begin exe_cmd_o = EXE_SRL; wb_en_o = 1'b1; uses_src2_o = 1'b1; end
            OP_ADDI: begin exe_cmd_o = EXE_ADD; wb_en_o = 1'b1; is_imm_o = 1'b1; end
            OP_SUBI: begin exe_cmd_o = EXE_SUB; wb_en_o = 1'b1; is_imm_o = 1'b1; end
            OP_LD:   begin exe_cmd_o = EXE_ADD; wb_en_o = 1'b1; mem_r_en_o = 1'b1; is_imm_o = 1'b1; end
            // Store address is base + imm; rt carries the store data, so it is a real source.
            OP_ST:   begin exe_cmd_o = EXE_ADD; mem_w_en_o = 1'b1; is_imm_o = 1'b1; uses_src2_o = 1'b1; end
            OP_BEZ:  begin br_type_o = BR_BEZ; is_imm_o = 1'b1; end
            OP_BNE:  begin br_type_o = BR_BNE; is_imm_o = 1'b1; uses_src2_o = 1'b1; end
            OP_JMP:  begin br_type_o = BR_JMP; is_imm_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register, load-use bubble insertion, flush/stall control and bubble counter.
// Optional build macro ID_WB_BYPASS_EN forwards the write-back port into Val1/Reg2.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int BR_SHIFT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_mem_r_en,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              wb_en_in,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_value,
    output logic [REG_AW-1:0] src1,
    output logic [REG_AW-1:0] src2,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] ex_reg2,
    output logic [REG_AW-1:0] ex_dst_o,
    output logic [3:0]        ex_cmd,
    output logic [1:0]        ex_br_type,
    output logic              ex_mem_r_en_o,
    output logic              ex_mem_w_en,
    output logic              ex_wb_en,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [3:0]        dec_cmd;
    logic [1:0]        dec_br_type;
    logic              dec_wb_en;
    logic              dec_mem_r_en;
    logic              dec_mem_w_en;
    logic              dec_is_imm;
    logic              dec_uses_src2;

    logic [REG_AW-1:0] dst_dec;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] val1_src;
    logic [DATA_W-1:0] reg2_src;
    logic [DATA_W-1:0] val2_dec;
    logic              hazard;

    id_ex_ctrl_t       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] val1_q, val1_d;
    logic [DATA_W-1:0] val2_q, val2_d;
    logic [DATA_W-1:0] reg2_q, reg2_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    id_decoder u_dec (
        .opcode_i    (instruction[31:26]),
        .exe_cmd_o   (dec_cmd),
        .br_type_o   (dec_br_type),
        .wb_en_o     (dec_wb_en),
        .mem_r_en_o  (dec_mem_r_en),
        .mem_w_en_o  (dec_mem_w_en),
        .is_imm_o    (dec_is_imm),
        .uses_src2_o (dec_uses_src2)
    );

    assign src1    = REG_AW'(instruction[25:21]);
    assign src2    = REG_AW'(instruction[20:16]);
    assign dst_dec = dec_is_imm ? REG_AW'(instruction[20:16]) : REG_AW'(instruction[15:11]);
    assign imm_ext = DATA_W'($signed(instruction[15:0]));

`ifdef ID_WB_BYPASS_EN
    logic wb_hit;
    assign wb_hit   = wb_en_in && (wb_dst != '0);
    assign val1_src = (wb_hit && (wb_dst == src1)) ? wb_value : reg1;
    assign reg2_src = (wb_hit && (wb_dst == src2)) ? wb_value : reg2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en_in, wb_dst, wb_value};
    assign val1_src  = reg1;
    assign reg2_src  = reg2;
`endif

    always_comb begin
        val2_dec = reg2_src;
        if (dec_is_imm) begin
            if (dec_br_type != BR_NONE) val2_dec = imm_ext << BR_SHIFT;
            else                        val2_dec = imm_ext;
        end
    end

    assign hazard = in_valid && ex_mem_r_en && (ex_dst != '0) &&
                    ((ex_dst == src1) || (dec_uses_src2 && (ex_dst == src2)));

    assign stall_out = !flush && (ex_stall || hazard);

    // Bubbles clear control and dst only; data fields keep their last value since nothing consumes them.
    always_comb begin
        ctrl_d = ctrl_q;
        pc_d   = pc_q;
        val1_d = val1_q;
        val2_d = val2_q;
        reg2_d = reg2_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        if (flush) begin
            ctrl_d = '0;
            dst_d  = '0;
        end else if (!ex_stall) begin
            if (hazard) begin
                ctrl_d = '0;
                dst_d  = '0;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                ctrl_d.valid    = in_valid;
                ctrl_d.cmd      = dec_cmd;
                ctrl_d.br_type  = in_valid ? dec_br_type : BR_NONE;
                ctrl_d.mem_r_en = in_valid && dec_mem_r_en;
                ctrl_d.mem_w_en = in_valid && dec_mem_w_en;
                ctrl_d.wb_en    = in_valid && dec_wb_en;
                pc_d            = pc_in;
                val1_d          = val1_src;
                val2_d          = val2_dec;
                reg2_d          = reg2_src;
                dst_d           = in_valid ? dst_dec : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            pc_q   <= '0;
            val1_q <= '0;
            val2_q <= '0;
            reg2_q <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc_q   <= pc_d;
            val1_q <= val1_d;
            val2_q <= val2_d;
            reg2_q <= reg2_d;
            dst_q  <= dst_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_cmd        = ctrl_q.cmd;
    assign ex_br_type    = ctrl_q.br_type;
    assign ex_mem_r_en_o = ctrl_q.mem_r_en;
    assign ex_mem_w_en   = ctrl_q.mem_w_en;
    assign ex_wb_en      = ctrl_q.wb_en;
    assign ex_pc         = pc_q;
    assign ex_val1       = val1_q;
    assign ex_val2       = val2_q;
    assign ex_reg2       = reg2_q;
    assign ex_dst_o      = dst_q;
    assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table plus hazard/flush/stall/reset/bypass/saturation sequences.
module tb_id_stage_pipe;
    import id_pkg::*;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] pc_in, reg1, reg2;
    logic [4:0]  ex_dst;
    logic        ex_mem_r_en, flush, ex_stall;
    logic        wb_en_in;
    logic [4:0]  wb_dst;
    logic [31:0] wb_value;
    logic [4:0]  src1, src2;
    logic        stall_out;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_val1, ex_val2, ex_reg2;
    logic [4:0]  ex_dst_o;
    logic [3:0]  ex_cmd;
    logic [1:0]  ex_br_type;
    logic        ex_mem_r_en_o, ex_mem_w_en, ex_wb_en;
    logic [CW-1:0] bubble_count;

    int n_chk = 0;
    int n_fail = 0;

    id_stage_pipe #(.DATA_W(32), .REG_AW(5), .BR_SHIFT(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
        .reg1(reg1), .reg2(reg2), .ex_dst(ex_dst), .ex_mem_r_en(ex_mem_r_en), .flush(flush),
        .ex_stall(ex_stall), .wb_en_in(wb_en_in), .wb_dst(wb_dst), .wb_value(wb_value),
        .src1(src1), .src2(src2), .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_reg2(ex_reg2), .ex_dst_o(ex_dst_o),
        .ex_cmd(ex_cmd), .ex_br_type(ex_br_type), .ex_mem_r_en_o(ex_mem_r_en_o),
        .ex_mem_w_en(ex_mem_w_en), .ex_wb_en(ex_wb_en), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] r1, r2;
        logic        vld;
        logic [31:0] e_val1, e_val2, e_reg2;
        logic [4:0]  e_dst;
        logic [3:0]  e_cmd;
        logic [1:0]  e_br;
        logic        e_mr, e_mw, e_wb;
    } vec_t;

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[11];
    logic [31:0] iw;
    logic [31:0] hold_val1, hold_val2;

    initial begin
        rst = 1'b1; in_valid = 1'b0; instruction = '0; pc_in = '0; reg1 = '0; reg2 = '0;
        ex_dst = '0; ex_mem_r_en = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        wb_en_in = 1'b0; wb_dst = '0; wb_value = '0;

        //            instr                           r1          r2          vld  val1        val2          reg2        dst     cmd      br      mr    mw    wb
        vt[0]  = '{mk_i(OP_ADDI, 1, 2, 16'hFFFC),    32'd10,     32'd99,     1'b1, 32'd10,     32'hFFFFFFFC, 32'd99,     5'd2,  EXE_ADD, BR_NONE, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{mk_i(OP_BNE, 1, 2, 16'd3),        32'd5,      32'd7,      1'b1, 32'd5,      32'd12,       32'd7,      5'd2,  EXE_NOP, BR_BNE,  1'b0, 1'b0, 1'b0};
        vt[2]  = '{mk_r(OP_ADD, 3, 5, 4),            32'd3,      32'd4,      1'b1, 32'd3,      32'd4,        32'd4,      5'd4,  EXE_ADD, BR_NONE, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{mk_i(OP_LD, 7, 6, 16'd8),         32'h1000,   32'h22,     1'b1, 32'h1000,   32'd8,        32'h22,     5'd6,  EXE_ADD, BR_NONE, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{mk_i(OP_ST, 9, 8, 16'hFFFE),      32'h2000,   32'hABCD,   1'b1, 32'h2000,   32'hFFFFFFFE, 32'hABCD,   5'd8,  EXE_ADD, BR_NONE, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{mk_r(OP_SUB, 11, 12, 10),         32'd50,     32'd8,      1'b1, 32'd50,     32'd8,        32'd8,      5'd10, EXE_SUB, BR_NONE, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{mk_i(OP_JMP, 0, 0, 16'h0010),     32'd0,      32'd0,      1'b1, 32'd0,      32'h40,       32'd0,      5'd0,  EXE_NOP, BR_JMP,  1'b0, 1'b0, 1'b0};
        vt[7]  = '{mk_i(OP_BEZ, 1, 0, 16'hFFFF),     32'd0,      32'd0,      1'b1, 32'd0,      32'hFFFFFFFC, 32'd0,      5'd0,  EXE_NOP, BR_BEZ,  1'b0, 1'b0, 1'b0};
        vt[8]  = '{mk_r(OP_ADD, 3, 5, 4),            32'd1,      32'd2,      1'b0, 32'd1,      32'd2,        32'd2,      5'd0,  EXE_ADD, BR_NONE, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{mk_r(OP_SLL, 1, 2, 3),            32'd1,      32'd4,      1'b1, 32'd1,      32'd4,        32'd4,      5'd3,  EXE_SLL, BR_NONE, 1'b0, 1'b0, 1'b1};
        vt[10] = '{mk_i(OP_SUBI, 4, 13, 16'h7FFF),   32'd9,      32'd1,      1'b1, 32'd9,      32'h00007FFF, 32'd1,      5'd13, EXE_SUB, BR_NONE, 1'b0, 1'b0, 1'b1};

        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_val1", ex_val1, 0);
        chk("rst_val2", ex_val2, 0);
        chk("rst_dst", ex_dst_o, 0);
        chk("rst_wb", ex_wb_en, 0);
        chk("rst_cnt", bubble_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            iw = vt[i].instr;
            instruction = iw; reg1 = vt[i].r1; reg2 = vt[i].r2; in_valid = vt[i].vld;
            pc_in = 32'h100 + 32'(4 * i);
            #1;
            chk($sformatf("v%0d_src1", i), src1, iw[25:21]);
            chk($sformatf("v%0d_src2", i), src2, iw[20:16]);
            chk($sformatf("v%0d_stall", i), stall_out, 0);
            tick();
            chk($sformatf("v%0d_valid", i), ex_valid, vt[i].vld);
            chk($sformatf("v%0d_pc", i), ex_pc, 32'h100 + 32'(4 * i));
            chk($sformatf("v%0d_val1", i), ex_val1, vt[i].e_val1);
            chk($sformatf("v%0d_val2", i), ex_val2, vt[i].e_val2);
            chk($sformatf("v%0d_reg2", i), ex_reg2, vt[i].e_reg2);
            chk($sformatf("v%0d_dst", i), ex_dst_o, vt[i].e_dst);
            chk($sformatf("v%0d_cmd", i), ex_cmd, vt[i].e_cmd);
            chk($sformatf("v%0d_br", i), ex_br_type, vt[i].e_br);
            chk($sformatf("v%0d_mr", i), ex_mem_r_en_o, vt[i].e_mr);
            chk($sformatf("v%0d_mw", i), ex_mem_w_en, vt[i].e_mw);
            chk($sformatf("v%0d_wb", i), ex_wb_en, vt[i].e_wb);
        end
        chk("cnt_after_vectors", bubble_count, 0);

        // Load-use on src1: one bubble, then the ADD issues.
        in_valid = 1'b1; instruction = mk_r(OP_ADD, 3, 5, 4); reg1 = 32'd11; reg2 = 32'd22;
        ex_dst = 5'd3; ex_mem_r_en = 1'b1;
        #1 chk("hz_stall", stall_out, 1);
        tick();
        chk("hz_bub_valid", ex_valid, 0);
        chk("hz_bub_wb", ex_wb_en, 0);
        chk("hz_bub_mr", ex_mem_r_en_o, 0);
        chk("hz_bub_dst", ex_dst_o, 0);
        chk("hz_cnt", bubble_count, 1);
        ex_mem_r_en = 1'b0;
        #1 chk("hz_release", stall_out, 0);
        tick();
        chk("hz_issue_valid", ex_valid, 1);
        chk("hz_issue_dst", ex_dst_o, 4);
        chk("hz_issue_val1", ex_val1, 11);
        chk("hz_cnt_hold", bubble_count, 1);

        // Combinational hazard qualifiers.
        ex_mem_r_en = 1'b1; ex_dst = 5'd5;
        #1 chk("hz_src2_rtype", stall_out, 1);
        instruction = mk_i(OP_ADDI, 1, 5, 16'd1);
        #1 chk("hz_src2_itype", stall_out, 0);
        ex_dst = 5'd0; instruction = mk_i(OP_ADDI, 0, 2, 16'd1);
        #1 chk("hz_r0", stall_out, 0);
        ex_dst = 5'd3; instruction = mk_r(OP_ADD, 3, 5, 4); in_valid = 1'b0;
        #1 chk("hz_invalid", stall_out, 0);
        in_valid = 1'b1;

        // Flush together with hazard: flush wins, no count.
        flush = 1'b1;
        #1 chk("fl_stall", stall_out, 0);
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_wb", ex_wb_en, 0);
        chk("fl_cnt", bubble_count, 1);
        flush = 1'b0; ex_mem_r_en = 1'b0;

        // Stall hold with a concurrent hazard, then async reset mid-stall.
        instruction = mk_i(OP_ADDI, 1, 2, 16'hFFFC); reg1 = 32'd10;
        tick();
        chk("st_load_val1", ex_val1, 10);
        hold_val1 = 32'd10; hold_val2 = 32'hFFFFFFFC;
        ex_stall = 1'b1; instruction = mk_r(OP_ADD, 3, 5, 4); reg1 = 32'd77; reg2 = 32'd88;
        ex_dst = 5'd3; ex_mem_r_en = 1'b1;
        #1 chk("st_stall_out", stall_out, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("st%0d_val1", c), ex_val1, hold_val1);
            chk($sformatf("st%0d_val2", c), ex_val2, hold_val2);
            chk($sformatf("st%0d_dst", c), ex_dst_o, 2);
            chk($sformatf("st%0d_valid", c), ex_valid, 1);
            chk($sformatf("st%0d_cnt", c), bubble_count, 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("rs_valid", ex_valid, 0);
        chk("rs_val1", ex_val1, 0);
        chk("rs_val2", ex_val2, 0);
        chk("rs_pc", ex_pc, 0);
        chk("rs_wb", ex_wb_en, 0);
        chk("rs_cnt", bubble_count, 0);
        #1 rst = 1'b0;
        ex_stall = 1'b0; ex_mem_r_en = 1'b0;
        instruction = mk_i(OP_ADDI, 1, 2, 16'hFFFC); reg1 = 32'd10;
        tick();
        chk("rs_after_valid", ex_valid, 1);
        chk("rs_after_val1", ex_val1, 10);
        chk("rs_after_dst", ex_dst_o, 2);

        // Write-back bypass.
        wb_en_in = 1'b1; wb_dst = 5'd1; wb_value = 32'h55; reg1 = 32'd0;
        tick();
`ifdef ID_WB_BYPASS_EN
        chk("byp_val1", ex_val1, 32'h55);
`else
        chk("byp_val1", ex_val1, 32'h0);
`endif
        instruction = mk_r(OP_ADD, 3, 1, 4); reg1 = 32'd2; reg2 = 32'd9;
        tick();
`ifdef ID_WB_BYPASS_EN
        chk("byp_val2", ex_val2, 32'h55);
        chk("byp_reg2", ex_reg2, 32'h55);
`else
        chk("byp_val2", ex_val2, 32'd9);
        chk("byp_reg2", ex_reg2, 32'd9);
`endif
        chk("byp_val1_nohit", ex_val1, 32'd2);
        wb_en_in = 1'b0;

        // Counter saturation (CNT_W = 4).
        instruction = mk_r(OP_ADD, 3, 5, 4); ex_dst = 5'd3; ex_mem_r_en = 1'b1;
        repeat (14) tick();
        chk("sat_14", bubble_count, 14);
        repeat (6) tick();
        chk("sat_max", bubble_count, 15);
        ex_mem_r_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage with its own ID/EX pipeline register, internal load-use hazard detection, and flush/stall control. It sits between the IF/ID register and the EXE stage:
- decodes the instruction;
- drives register-file read addresses;
- builds Val1/Val2;
- registers all EXE-bound fields.

It also inserts bubbles on load-use hazards, squashes on branch flush, holds on downstream stall, and counts inserted bubbles.

## Interface
- DATA_W, 32, datapath width (instruction fixed at 32 bits)
- REG_AW, 5, register address width
- BR_SHIFT, 2, left shift applied to branch immediates
- CNT_W, 16, bubble counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  fetched instruction
- pc_in  in  DATA_W  PC of instruction
- reg1, reg2  in  DATA_W  register-file read data (combinational)
- ex_dst  in  REG_AW  destination of instruction currently in EXE
- ex_mem_r_en  in  1  instruction in EXE is a load
- flush  in  1  taken branch resolved; squash ID
- ex_stall  in  1  downstream stall; hold ID/EX
- wb_en_in, wb_dst, wb_value  in  1/REG_AW/DATA_W  write-back port (used only with bypass)
- src1, src2  out  REG_AW  register-file read addresses (combinational)
- stall_out  out  1  hold PC and IF/ID (combinational)
- ex_valid, ex_pc, ex_val1, ex_val2, ex_reg2, ex_dst_o  out  1/DATA_W/DATA_W/DATA_W/DATA_W/REG_AW  registered
- ex_cmd, ex_br_type, ex_mem_r_en_o, ex_mem_w_en, ex_wb_en  out  4/2/1/1/1  registered
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Decode (combinational):
  - src1 = instruction[25:21], src2 = instruction[20:16].
  - dst = [15:11] for R-type, [20:16] for I-type.
  - Immediate = sign-extended [15:0] to DATA_W.
  - Val2 = immediate << BR_SHIFT when br_type != 0 and I-type; immediate when I-type otherwise; reg2 for R-type.
  - Val1 = reg1; Reg2 = reg2.
- uses_src2 = R-type, store (ST), or BNE.
- Load-use hazard = in_valid && ex_mem_r_en && ex_dst != 0 && (ex_dst == src1 || (uses_src2 && ex_dst == src2)).
- Priority on each rising edge:
  1. rst
  2. flush
  3. ex_stall
  4. hazard
  5. normal
- flush: ID/EX loaded with a bubble (ex_valid = 0 and all enables 0); hazard ignored.
- ex_stall: ID/EX holds every field unchanged.
- hazard: bubble loaded; bubble_count increments.
- normal: decoded fields loaded; ex_valid = in_valid; enables gated by in_valid.
- stall_out = !flush && (ex_stall || hazard).
- A bubble always has ex_wb_en = ex_mem_r_en_o = ex_mem_w_en = 0, ex_br_type = 0, ex_dst_o = 0.
- bubble_count saturates at all-ones. It is not incremented on flush or on held cycles.

## Timing
- Reset (asynchronous, immediate): all registered outputs 0, bubble_count 0.
- Latency:
  - decode to ex_* outputs: 1 cycle;
  - src1/src2/stall_out: 0 cycles.
- A hazard lasts exactly one cycle per load. On the next cycle ex_mem_r_en is the bubble's 0, so the held instruction issues.
- Simultaneous flush and hazard: flush wins, no count, stall_out = 0.
- Simultaneous ex_stall and hazard: hold wins, no count, stall_out = 1.
- Reset mid-stall: everything clears, and the next edge after release decodes normally.

## Configuration
- ID_WB_BYPASS_EN:
  - Defined: if wb_en_in && wb_dst != 0, then wb_dst == src1 replaces Val1 with wb_value, and wb_dst == src2 replaces reg2 (in Val2 for R-type and in Reg2).
  - Undefined: wb_* ports are present but ignored; values come from the register file only.

## Structure
- Package id_pkg holds:
  - opcode constants (ADD=1, SUB=3, AND=5, OR=6, NOR=7, XOR=8, SLA=9, SLL=10, SRA=11, SRL=12, ADDI=32, SUBI=33, LD=36, ST=37, BEZ=40, BNE=41, JMP=42);
  - exe_cmd encodings;
  - br_type encodings (0 none, 1 BEZ, 2 BNE, 3 JMP);
  - the id_ex bundle struct.
- One sub-module: id_decoder, a pure combinational control unit (opcode to exe_cmd, enables, is_imm, br_type, uses_src2).

## Test plan
- ADDI r2, r1, -4 with reg1 = 10, normal flow: next edge gives ex_val1 = 10, ex_val2 = 0xFFFFFFFC, ex_dst_o = 2, ex_wb_en = 1.
- BNE r1, r2, imm = 3 with reg2 = 7: ex_val2 = 12, ex_br_type = 2, ex_reg2 = 7, ex_wb_en = 0.
- LD r3 in EXE, then ADD r4, r3, r5 in ID:
  - stall_out = 1 for one cycle and a bubble is issued;
  - bubble_count goes 0 to 1;
  - the ADD issues on the following edge.
- Flush asserted on the same cycle as a load-use hazard: bubble, stall_out = 0, bubble_count unchanged.
- ex_stall high for 3 cycles: ex_* outputs constant; rst pulse mid-stall clears all outputs asynchronously.
- With ID_WB_BYPASS_EN, wb_dst = 1, wb_value = 0x55, src1 = 1, reg1 = 0: ex_val1 = 0x55. Without the macro: ex_val1 = 0.
